// File: rtl/multitrig_pkg.sv
// Shared types and helpers for the multitrig coincidence/sum trigger.
// Default geometry, FSM state encoding, sum width and popcount.
package multitrig_pkg;

   localparam int NCH_DEF   = 4;
   localparam int DW_DEF    = 16;
   localparam int DEADT_DEF = 8;

   typedef enum logic [1:0] {
      ARMED = 2'd0,
      DEAD  = 2'd1,
      FIRED = 2'd2
   } state_t;

   // Sum of nch signed dw-bit samples never overflows this width.
   function automatic int sum_width(input int dw, input int nch);
      return dw + $clog2(nch);
   endfunction

   localparam int SUMW = sum_width(DW_DEF, NCH_DEF);

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/multitrig_extsync.sv
// External trigger: 2-FF synchroniser followed by a rising-edge detector.
// One-cycle rise pulse per low-to-high transition; cleared by reset.
module multitrig_extsync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = async_in;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/multitrig.sv
// N-channel multiplicity + sum trigger with dead time, hysteresis and synced external trigger.
// Sample -> trig in 3 cycles. Optional trig_cnt port when MULTITRIG_CNT_EN is defined.
module multitrig
   import multitrig_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEADT = DEADT_DEF
) (
   input  logic              ADCCLK,
   input  logic              reset,
   input  logic [NCH*DW-1:0] dpdata,
   input  logic [15:0]       ithr,
   input  logic [15:0]       sthr,
   input  logic [3:0]        mult,
   input  logic              inhibit,
   input  logic              exttrig,
   output logic              trig,
   output logic [NCH-1:0]    trig_mask
`ifdef MULTITRIG_CNT_EN
   ,output logic [31:0]      trig_cnt
`endif
);

   localparam int SW   = sum_width(DW, NCH);
   // Compare widths leave room for a zero-extended 16-bit threshold.
   localparam int CW   = ((DW > 16) ? DW : 16) + 1;
   localparam int SCW  = ((SW > 16) ? SW : 16) + 1;
   localparam int CNTW = (DEADT > 1) ? $clog2(DEADT) : 1;
   localparam logic [CNTW-1:0] DEAD_LOAD = (DEADT > 0) ? CNTW'(DEADT - 1) : '0;

   logic [NCH*DW-1:0]    s1_q, s1_d;
   logic [NCH-1:0]       over_q, over_d;
   logic [3:0]           pcnt_q, pcnt_d;
   logic signed [SW-1:0] sum_q, sum_d;
   logic                 inh_q, inh_d;
   state_t               state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 trig_q, trig_d;
   logic [NCH-1:0]       mask_q, mask_d;

   logic       ext_rise;
   logic [3:0] mult_eff;
   logic       cond, rearm, self_fire;

   multitrig_extsync u_ext (
      .clk      (ADCCLK),
      .reset    (reset),
      .async_in (exttrig),
      .rise     (ext_rise)
   );

   always_comb begin
      s1_d   = dpdata;
      inh_d  = inhibit;
      over_d = '0;
      sum_d  = '0;
      for (int k = 0; k < NCH; k++) begin
         over_d[k] = CW'($signed(s1_q[k*DW +: DW])) > $signed(CW'({1'b0, ithr}));
         sum_d     = sum_d + SW'($signed(s1_q[k*DW +: DW]));
      end
      pcnt_d = popcount(8'(over_d));
   end

   always_comb begin
      mult_eff = (mult == 4'd0) ? 4'd1 : mult;
      cond     = (pcnt_q >= mult_eff) && (SCW'(sum_q) > $signed(SCW'({1'b0, sthr})));
      rearm    = SCW'(sum_q) <= $signed(SCW'({2'b00, sthr[15:1]}));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (inh_q) begin
         state_d = ARMED;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ARMED: if (cond) begin
               cnt_d   = DEAD_LOAD;
               state_d = (DEADT > 0) ? DEAD : FIRED;
            end
            DEAD: begin
               if (cnt_q == '0) state_d = FIRED;
               else             cnt_d   = cnt_q - CNTW'(1);
            end
            FIRED: if (rearm) state_d = ARMED;
            default: state_d = ARMED;
         endcase
      end
   end

   // External edges bypass inhibit and the FSM; a coincident self trigger merges into one pulse.
   always_comb begin
      self_fire = ~inh_q && (state_q == ARMED) && cond;
      trig_d    = self_fire | ext_rise;
      mask_d    = self_fire ? over_q : mask_q;
   end

   always_ff @(posedge ADCCLK) begin
      if (reset) begin
         s1_q    <= '0;
         over_q  <= '0;
         pcnt_q  <= '0;
         sum_q   <= '0;
         inh_q   <= 1'b0;
         state_q <= ARMED;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         s1_q    <= s1_d;
         over_q  <= over_d;
         pcnt_q  <= pcnt_d;
         sum_q   <= sum_d;
         inh_q   <= inh_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         mask_q  <= mask_d;
      end
   end

   assign trig      = trig_q;
   assign trig_mask = mask_q;

`ifdef MULTITRIG_CNT_EN
   logic [31:0] tcnt_q, tcnt_d;

   always_comb begin
      tcnt_d = trig_d ? tcnt_q + 32'd1 : tcnt_q;
   end

   always_ff @(posedge ADCCLK) begin
      if (reset) tcnt_q <= '0;
      else       tcnt_q <= tcnt_d;
   end

   assign trig_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_multitrig.sv
// Bench for multitrig: directed scenarios plus random traffic against a cycle-indexed
// behavioural model built from recorded input history.
module tb_multitrig;

   localparam int NCH   = 4;
   localparam int DW    = 16;
   localparam int DEADT = 8;
   localparam int MAXC  = 8192;

   logic          ADCCLK = 1'b0;
   logic          reset;
   logic [63:0]   dpdata;
   logic [15:0]   ithr, sthr;
   logic [3:0]    mult;
   logic          inhibit, exttrig;
   logic          trig;
   logic [3:0]    trig_mask;
`ifdef MULTITRIG_CNT_EN
   logic [31:0]   trig_cnt;
`endif

   always #5 ADCCLK = ~ADCCLK;

   multitrig #(.NCH(NCH), .DW(DW), .DEADT(DEADT)) dut (
      .ADCCLK    (ADCCLK),
      .reset     (reset),
      .dpdata    (dpdata),
      .ithr      (ithr),
      .sthr      (sthr),
      .mult      (mult),
      .inhibit   (inhibit),
      .exttrig   (exttrig),
      .trig      (trig),
      .trig_mask (trig_mask)
`ifdef MULTITRIG_CNT_EN
      ,.trig_cnt (trig_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc = 0, last_rst = 0, pulses = 0;

   logic [63:0] h_d    [MAXC];
   bit          h_inh  [MAXC];
   bit          h_ext  [MAXC];
   int          h_ithr [MAXC];
   int          h_sthr [MAXC];
   int          h_mult [MAXC];

   // Model: mode 0 armed, 1 dead (m_dead cycles left), 2 waiting for rearm.
   int          m_mode, m_dead;
   logic [3:0]  m_mask;
   bit          m_trig;
   logic [31:0] m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] samp(input int i);
      if (i <= last_rst) return 64'd0;
      return h_d[i];
   endfunction

   function automatic bit extv(input int i);
      if (i <= last_rst) return 1'b0;
      return h_ext[i];
   endfunction

   task automatic model_edge(input int e);
      logic [63:0]       d;
      logic signed [15:0] v;
      logic [3:0]        ov;
      int                sum, m;
      bit                cond, rearm, inh, ext, self_t;
      d   = samp(e - 2);
      sum = 0;
      ov  = '0;
      for (int k = 0; k < NCH; k++) begin
         v   = d[k*DW +: DW];
         sum = sum + int'(v);
         if (int'(v) > h_ithr[e-1]) ov[k] = 1'b1;
      end
      m      = (h_mult[e] == 0) ? 1 : h_mult[e];
      cond   = ($countones(ov) >= m) && (sum > h_sthr[e]);
      rearm  = sum <= (h_sthr[e] / 2);
      inh    = h_inh[e-1];
      ext    = extv(e - 2) && !extv(e - 3);
      self_t = 1'b0;
      if (inh) begin
         m_mode = 0;
         m_dead = 0;
      end else if (m_mode == 0) begin
         if (cond) begin
            self_t = 1'b1;
            m_mask = ov;
            if (DEADT > 0) begin
               m_mode = 1;
               m_dead = DEADT;
            end else begin
               m_mode = 2;
            end
         end
      end else if (m_mode == 1) begin
         m_dead--;
         if (m_dead == 0) m_mode = 2;
      end else if (rearm) begin
         m_mode = 0;
      end
      m_trig = self_t | ext;
      if (m_trig) m_cnt = m_cnt + 32'd1;
   endtask

   task automatic tick();
      if (cyc >= MAXC) begin
         $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, MAXC);
         $fatal(1);
      end
      h_d[cyc]    = reset ? 64'd0 : dpdata;
      h_inh[cyc]  = reset ? 1'b0  : inhibit;
      h_ext[cyc]  = reset ? 1'b0  : exttrig;
      h_ithr[cyc] = int'(ithr);
      h_sthr[cyc] = int'(sthr);
      h_mult[cyc] = int'(mult);
      @(posedge ADCCLK);
      if (reset) begin
         last_rst = cyc;
         m_mode = 0; m_dead = 0; m_mask = '0; m_trig = 1'b0; m_cnt = '0;
      end else begin
         model_edge(cyc);
      end
      @(negedge ADCCLK);
      check_eq("trig", 32'(trig), 32'(m_trig));
      check_eq("trig_mask", 32'(trig_mask), 32'(m_mask));
`ifdef MULTITRIG_CNT_EN
      check_eq("trig_cnt", trig_cnt, m_cnt);
`endif
      if (trig) pulses++;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic set_ch(input int a, input int b, input int c, input int d);
      dpdata[15:0]  = 16'(a);
      dpdata[31:16] = 16'(b);
      dpdata[47:32] = 16'(c);
      dpdata[63:48] = 16'(d);
   endtask

   function automatic int rnd_ch();
      case ($urandom_range(19))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(1000)) - 400;
      endcase
   endfunction

   initial begin
      int  p0;
      bit  seen;
      reset = 1'b1; dpdata = '0; ithr = 16'd100; sthr = 16'd600; mult = 4'd3;
      inhibit = 1'b0; exttrig = 1'b0;
      run(3);
      check_eq("reset_trig", 32'(trig), 32'd0);
      check_eq("reset_mask", 32'(trig_mask), 32'd0);
      reset = 1'b0;
      run(3);

      // three channels over threshold, fourth below: one trigger, mask 0111
      p0 = pulses;
      set_ch(200, 200, 200, 50); run(10);
      set_ch(0, 0, 0, 0);        run(12);
      check_eq("three_ch_pulses", 32'(pulses - p0), 32'd1);
      check_eq("three_ch_mask", 32'(trig_mask), 32'h7);

      // two channels, sum 400: below multiplicity and sum threshold
      p0 = pulses;
      set_ch(200, 200, 0, 0); run(10);
      set_ch(0, 0, 0, 0);     run(5);
      check_eq("two_ch_nofire", 32'(pulses - p0), 32'd0);
      mult = 4'd2; sthr = 16'd300;
      set_ch(200, 200, 0, 0); run(10);
      set_ch(0, 0, 0, 0);     run(12);
      check_eq("two_ch_pulses", 32'(pulses - p0), 32'd1);
      check_eq("two_ch_mask", 32'(trig_mask), 32'h3);

      // hysteresis: dropping only to 400 keeps the trigger disarmed
      mult = 4'd1; sthr = 16'd600; p0 = pulses;
      set_ch(200, 200, 200, 200); run(15);
      set_ch(100, 100, 100, 100); run(5);
      set_ch(200, 200, 200, 200); run(15);
      check_eq("hyst_no_retrig", 32'(pulses - p0), 32'd1);
      set_ch(75, 75, 75, 75);     run(5);
      set_ch(200, 200, 200, 200); run(10);
      check_eq("hyst_retrig", 32'(pulses - p0), 32'd2);
      set_ch(0, 0, 0, 0);         run(15);

      // external edge during dead time, then held high
      p0 = pulses; seen = 1'b0;
      set_ch(200, 200, 200, 200); run(1);
      set_ch(0, 0, 0, 0);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (trig) seen = 1'b1;
      end
      check_eq("self_trig_seen", 32'(seen), 32'd1);
      run(3);
      exttrig = 1'b1; run(20);
      exttrig = 1'b0; run(10);
      check_eq("ext_dead_pulses", 32'(pulses - p0), 32'd2);

      // inhibit blocks self triggers but not external ones
      p0 = pulses;
      inhibit = 1'b1;
      set_ch(200, 200, 200, 200); run(4);
      exttrig = 1'b1; run(2);
      exttrig = 1'b0; run(6);
      check_eq("inhibit_ext_only", 32'(pulses - p0), 32'd1);
      inhibit = 1'b0; run(10);
      check_eq("inhibit_release", 32'(pulses - p0), 32'd2);
      set_ch(0, 0, 0, 0); run(15);

      // reset while dead
      set_ch(200, 200, 200, 200); run(1);
      set_ch(0, 0, 0, 0);         run(4);
      reset = 1'b1; run(1);
      reset = 1'b0;
      check_eq("rst_dead_mask", 32'(trig_mask), 32'd0);
`ifdef MULTITRIG_CNT_EN
      check_eq("rst_dead_cnt", trig_cnt, 32'd0);
`endif
      run(5);

      // random traffic
      for (int blk = 0; blk < 20; blk++) begin
         ithr = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(300));
         sthr = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(1500));
         mult = 4'($urandom_range(6));
         for (int i = 0; i < 100; i++) begin
            set_ch(rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch());
            if ($urandom_range(19) == 0) inhibit = ~inhibit;
            if ($urandom_range(7) == 0)  exttrig = ~exttrig;
            reset = ($urandom_range(299) == 0);
            tick();
         end
      end
      reset = 1'b0; inhibit = 1'b0; exttrig = 1'b0;
      set_ch(0, 0, 0, 0);
      run(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
